bus_xfer_ctrl: RTL and testbench

BUS_XFER_CTRL -- requirements
Module: bus_xfer_ctrl

---
 rtl/bus_xfer_ctrl.sv | 133 +++++++++++++
 tb/tb_bus_xfer_ctrl.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_xfer_ctrl.sv
// bus_xfer_ctrl: sequences one register-to-register move over a shared 8-bit bus.
// It drives the source slot's Oen for SETTLE_CYC cycles, then adds the destination
// slot's Inen for one latch cycle, then pulses done for one cycle.
// A request whose source and destination are the same slot is rejected:
// done and err pulse together one cycle later, and no enable is ever raised.
// Build option: define XFER_CAPTURE_EN to make last_data hold the bus value
// sampled at the latch cycle. When it is not defined, last_data is tied to 8'h00.
//
// Handshake: start is a level request that is only looked at in IDLE; it is never
// queued. busy is high from the first drive cycle through the latch cycle. done
// (and err, for a rejected request) is a single-cycle pulse in the DONE cycle.
// Holding start high therefore repeats transfers with period SETTLE_CYC+3.
module bus_xfer_ctrl #(
  parameter int unsigned SETTLE_CYC = 1
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       start,
  input  logic [1:0] src_sel,
  input  logic [1:0] dst_sel,
  input  logic [7:0] bus_in,
  output logic [3:0] Oen,
  output logic [3:0] Inen,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [7:0] last_data,
  output logic [1:0] dbg_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    LATCH = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Terminal value of the drive-phase counter (counts 0 .. SETTLE_CYC-1).
  localparam logic [3:0] CNT_LAST = 4'(SETTLE_CYC - 1);

  state_t     r_state;
  logic [3:0] r_cnt;
  logic [1:0] r_dst;

  function automatic logic [3:0] onehot(input logic [1:0] sel);
    logic [3:0] v;
    v      = 4'b0000;
    v[sel] = 1'b1;
    return v;
  endfunction

  // Transfer FSM. All outputs are registered alongside the state. The source
  // selection is kept only in the Oen register, which is loaded on the accepting
  // edge and held until the transfer ends. The destination is kept in r_dst.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
      r_dst   <= 2'd0;
      Oen     <= 4'b0000;
      Inen    <= 4'b0000;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            if (src_sel != dst_sel) begin
              r_state <= DRIVE;
              r_dst   <= dst_sel;
              r_cnt   <= 4'd0;
              Oen     <= onehot(src_sel);
              Inen    <= 4'b0000;
              busy    <= 1'b1;
            end else begin
              r_state <= DONE;
              done    <= 1'b1;
              err     <= 1'b1;
            end
          end
        end
        DRIVE: begin
          if (r_cnt == CNT_LAST) begin
            r_state <= LATCH;
            r_cnt   <= 4'd0;
            Inen    <= onehot(r_dst);
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        LATCH: begin
          r_state <= DONE;
          Oen     <= 4'b0000;
          Inen    <= 4'b0000;
          busy    <= 1'b0;
          done    <= 1'b1;
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign dbg_state = r_state;

`ifdef XFER_CAPTURE_EN
  logic [7:0] r_last_data;

  // Sample the bus on the edge that ends the latch cycle, which is the same edge the destination latches on.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_last_data <= 8'h00;
    end else if (r_state == LATCH) begin
      r_last_data <= bus_in;
    end
  end

  assign last_data = r_last_data;
`else
  // No capture register in this build; the bus is observed by nothing.
  logic w_unused_bus;
  assign w_unused_bus = ^bus_in;
  assign last_data    = 8'h00;
`endif

endmodule

// File: tb/tb_bus_xfer_ctrl.sv
// Bench for bus_xfer_ctrl. It runs two instances, SETTLE_CYC=1 and SETTLE_CYC=4,
// on shared stimulus. A timeline model turns every accepted request into the
// outputs it must produce in each future cycle. The model state is:
//   - expected per-cycle outputs, indexed by rising-edge count;
//   - the next edge at which a start can be accepted;
//   - the edge at which the bus value is captured.
// Directed scenarios add hand-computed literal expectations.
module tb_bus_xfer_ctrl;

  localparam int N     = 2;
  localparam int DEPTH = 1024;
  localparam int S0    = 1;
  localparam int S1    = 4;

`ifdef XFER_CAPTURE_EN
  localparam bit CAP = 1'b1;
`else
  localparam bit CAP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       clr = 1'b1;
  logic       start = 1'b0;
  logic [1:0] src_sel = 2'd0;
  logic [1:0] dst_sel = 2'd0;
  logic [7:0] bus_in = 8'h00;

  logic [1:0][3:0] oen;
  logic [1:0][3:0] inen;
  logic [1:0]      busy;
  logic [1:0]      done;
  logic [1:0]      err;
  logic [1:0][7:0] last;
  logic [1:0][1:0] dbg;

  int pass_cnt  = 0;
  int total_cnt = 0;

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  bus_xfer_ctrl #(.SETTLE_CYC(S0)) u_s1 (
    .clk(clk), .clr(clr), .start(start), .src_sel(src_sel), .dst_sel(dst_sel),
    .bus_in(bus_in), .Oen(oen[0]), .Inen(inen[0]), .busy(busy[0]), .done(done[0]),
    .err(err[0]), .last_data(last[0]), .dbg_state(dbg[0])
  );

  bus_xfer_ctrl #(.SETTLE_CYC(S1)) u_s4 (
    .clk(clk), .clr(clr), .start(start), .src_sel(src_sel), .dst_sel(dst_sel),
    .bus_in(bus_in), .Oen(oen[1]), .Inen(inen[1]), .busy(busy[1]), .done(done[1]),
    .err(err[1]), .last_data(last[1]), .dbg_state(dbg[1])
  );

  // ---------------- checking helper ----------------
  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp_v);
    total_cnt++;
    if (act === exp_v) pass_cnt++;
    else $display("FAIL %s actual=%h expected=%h", name, act, exp_v);
  endtask

  function automatic logic [7:0] capv(input logic [7:0] v);
    return CAP ? v : 8'h00;
  endfunction

  // ---------------- model ----------------
  logic [3:0] m_oen  [N][DEPTH];
  logic [3:0] m_inen [N][DEPTH];
  logic       m_busy [N][DEPTH];
  logic       m_done [N][DEPTH];
  logic       m_err  [N][DEPTH];
  logic [7:0] m_last [N];
  int         m_idle_at [N];
  int         m_cap_at  [N];
  int         s_of [N] = '{S0, S1};
  int         cyc = 0;

  function automatic logic [3:0] oh(input logic [1:0] sel);
    logic [3:0] r;
    r      = 4'b0000;
    r[sel] = 1'b1;
    return r;
  endfunction

  task automatic model_clear(input int from);
    for (int i = 0; i < N; i++) begin
      for (int k = from; k < DEPTH; k++) begin
        m_oen[i][k]  = 4'b0000;
        m_inen[i][k] = 4'b0000;
        m_busy[i][k] = 1'b0;
        m_done[i][k] = 1'b0;
        m_err[i][k]  = 1'b0;
      end
      m_last[i]    = 8'h00;
      m_idle_at[i] = 0;
      m_cap_at[i]  = -1;
    end
  endtask

  // Each edge either captures the bus or accepts a request and writes its future timeline.
  always @(posedge clk) begin
    cyc++;
    if (clr) begin
      for (int i = 0; i < N; i++) begin
        if (cyc == m_cap_at[i]) m_last[i] = capv(bus_in);
        if (cyc >= m_idle_at[i] && start && (cyc + s_of[i] + 3 < DEPTH)) begin
          if (src_sel != dst_sel) begin
            for (int k = 0; k <= s_of[i]; k++) begin
              m_oen[i][cyc+k]  = oh(src_sel);
              m_busy[i][cyc+k] = 1'b1;
            end
            m_inen[i][cyc+s_of[i]]   = oh(dst_sel);
            m_done[i][cyc+s_of[i]+1] = 1'b1;
            m_cap_at[i]              = cyc + s_of[i] + 1;
            m_idle_at[i]             = cyc + s_of[i] + 3;
          end else begin
            m_done[i][cyc] = 1'b1;
            m_err[i][cyc]  = 1'b1;
            m_idle_at[i]   = cyc + 2;
          end
        end
      end
    end
  end

  // Compare every output of both instances against the model on the falling edge.
  always @(negedge clk) begin
    if (cyc < DEPTH) begin
      for (int i = 0; i < N; i++) begin
        chk($sformatf("oen%0d@%0d", i, cyc),  {4'h0, oen[i]},  {4'h0, m_oen[i][cyc]});
        chk($sformatf("inen%0d@%0d", i, cyc), {4'h0, inen[i]}, {4'h0, m_inen[i][cyc]});
        chk($sformatf("busy%0d@%0d", i, cyc), {7'h0, busy[i]}, {7'h0, m_busy[i][cyc]});
        chk($sformatf("done%0d@%0d", i, cyc), {7'h0, done[i]}, {7'h0, m_done[i][cyc]});
        chk($sformatf("err%0d@%0d", i, cyc),  {7'h0, err[i]},  {7'h0, m_err[i][cyc]});
        chk($sformatf("last%0d@%0d", i, cyc), last[i],         m_last[i]);
      end
    end
  end

  // ---------------- driver ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  int n_edges, n_drive, n_latch, lat;
  int d_time [N][2];
  int d_cnt  [N];
  int p_src [4] = '{0, 2, 1, 3};
  int p_dst [4] = '{1, 3, 0, 2};

  initial begin
    model_clear(0);

    // Reset state
    #1 clr = 1'b0;
    #1;
    for (int i = 0; i < N; i++) begin
      chk($sformatf("rst_oen%0d", i),  {4'h0, oen[i]},  8'h00);
      chk($sformatf("rst_inen%0d", i), {4'h0, inen[i]}, 8'h00);
      chk($sformatf("rst_busy%0d", i), {7'h0, busy[i]}, 8'h00);
      chk($sformatf("rst_done%0d", i), {7'h0, done[i]}, 8'h00);
      chk($sformatf("rst_err%0d", i),  {7'h0, err[i]},  8'h00);
      chk($sformatf("rst_last%0d", i), last[i],         8'h00);
      chk($sformatf("rst_state%0d", i), {6'h0, dbg[i]}, 8'h00);
    end
    tick();
    tick();
    clr = 1'b1;

    // Basic transfer 1 -> 2 with SETTLE_CYC=1, bus 8'h23
    src_sel = 2'd1; dst_sel = 2'd2; bus_in = 8'h23; start = 1'b1;
    tick();
    start = 1'b0;
    chk("a_drive_oen",  {4'h0, oen[0]},  8'h02);
    chk("a_drive_inen", {4'h0, inen[0]}, 8'h00);
    chk("a_drive_busy", {7'h0, busy[0]}, 8'h01);
    tick();
    chk("a_latch_oen",  {4'h0, oen[0]},  8'h02);
    chk("a_latch_inen", {4'h0, inen[0]}, 8'h04);
    chk("a_latch_busy", {7'h0, busy[0]}, 8'h01);
    tick();
    chk("a_done",      {7'h0, done[0]}, 8'h01);
    chk("a_done_err",  {7'h0, err[0]},  8'h00);
    chk("a_done_oen",  {4'h0, oen[0]},  8'h00);
    chk("a_done_busy", {7'h0, busy[0]}, 8'h00);
    chk("a_last",      last[0],         capv(8'h23));
    repeat (6) tick();

    // Rejected request 3 -> 3
    src_sel = 2'd3; dst_sel = 2'd3; start = 1'b1;
    tick();
    start = 1'b0;
    chk("b_done0", {7'h0, done[0]}, 8'h01);
    chk("b_err0",  {7'h0, err[0]},  8'h01);
    chk("b_done1", {7'h0, done[1]}, 8'h01);
    chk("b_err1",  {7'h0, err[1]},  8'h01);
    chk("b_oen0",  {4'h0, oen[0]},  8'h00);
    chk("b_inen0", {4'h0, inen[0]}, 8'h00);
    tick();
    chk("b_done0_clr", {7'h0, done[0]}, 8'h00);
    repeat (2) tick();

    // SETTLE_CYC=4 instance: 0 -> 3, bus 8'hC6; sel scrambled mid-transfer
    src_sel = 2'd0; dst_sel = 2'd3; bus_in = 8'hC6; start = 1'b1;
    tick();
    start = 1'b0;
    n_edges = 1; n_drive = 0; n_latch = 0; lat = 0;
    while (n_edges <= 20 && lat == 0) begin
      if (oen[1] == 4'b0001 && inen[1] == 4'b0000) n_drive++;
      if (inen[1] == 4'b1000) n_latch++;
      if (done[1]) lat = n_edges;
      else begin
        src_sel = 2'(n_edges);
        dst_sel = 2'(n_edges + 1);
        tick();
        n_edges++;
      end
    end
    chk("c_drive_cycles", 8'(n_drive), 8'd4);
    chk("c_latch_cycles", 8'(n_latch), 8'd1);
    chk("c_latency",      8'(lat),     8'd6);
    chk("c_last",         last[1],     capv(8'hC6));
    repeat (3) tick();

    // start/sel activity while busy must be ignored
    src_sel = 2'd1; dst_sel = 2'd0; start = 1'b1;
    tick();
    for (int k = 1; k <= 3; k++) begin
      src_sel = 2'(k);
      dst_sel = 2'(k);
      tick();
      if (k == 2) begin
        chk("d_done0", {7'h0, done[0]}, 8'h01);
        chk("d_err0",  {7'h0, err[0]},  8'h00);
      end
    end
    start = 1'b0;
    tick();
    chk("d_latch_inen1", {4'h0, inen[1]}, 8'h01);
    chk("d_latch_oen1",  {4'h0, oen[1]},  8'h02);
    repeat (4) tick();

    // start held high with alternating pairs: back-to-back period S+3
    for (int i = 0; i < N; i++) begin
      d_cnt[i] = 0;
      d_time[i][0] = -100;
      d_time[i][1] = -100;
    end
    for (int j = 0; j < 21; j++) begin
      src_sel = 2'(p_src[j % 4]);
      dst_sel = 2'(p_dst[j % 4]);
      start = 1'b1;
      tick();
      for (int i = 0; i < N; i++) begin
        if (done[i] && d_cnt[i] < 2) begin
          d_time[i][d_cnt[i]] = cyc;
          d_cnt[i]++;
        end
      end
    end
    start = 1'b0;
    chk("e_period_s1", 8'(d_time[0][1] - d_time[0][0]), 8'd4);
    chk("e_period_s4", 8'(d_time[1][1] - d_time[1][0]), 8'd7);
    repeat (8) tick();

    // Reset during LATCH drops enables immediately, no done; recovery afterwards
    src_sel = 2'd2; dst_sel = 2'd0; bus_in = 8'h5A; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk("f_latch_inen0", {4'h0, inen[0]}, 8'h01);
    #1 clr = 1'b0;
    model_clear(cyc);
    #1;
    chk("f_rst_inen0", {4'h0, inen[0]}, 8'h00);
    chk("f_rst_oen0",  {4'h0, oen[0]},  8'h00);
    chk("f_rst_oen1",  {4'h0, oen[1]},  8'h00);
    chk("f_rst_busy0", {7'h0, busy[0]}, 8'h00);
    tick();
    tick();
    clr = 1'b1;
    src_sel = 2'd1; dst_sel = 2'd2; bus_in = 8'h77; start = 1'b1;
    tick();
    start = 1'b0;
    chk("f_rec_oen0", {4'h0, oen[0]}, 8'h02);
    tick();
    chk("f_rec_inen0", {4'h0, inen[0]}, 8'h04);
    tick();
    chk("f_rec_done0", {7'h0, done[0]}, 8'h01);
    chk("f_rec_last0", last[0],         capv(8'h77));
    repeat (8) tick();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  // Overall time bound
  initial begin
    #200000;
    total_cnt++;
    $display("FAIL timeout actual=running required=finished");
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
